// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready comes straight from a flop, so downstream stall logic never reaches
// upstream stages combinationally. Flush and reset leave a defined bubble on
// out_data. A saturating counter records how many live entries flush discarded.
module pipe_skid_stage #(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              up_fire;
  logic              dn_fire;
  logic [1:0]        dropped;
  logic [CNT_W:0]    drop_sum;

  assign out_valid  = (state_q != EMPTY);
  assign out_bubble = ~out_valid;
  assign out_data   = main_q;
  assign in_ready   = in_ready_q;
  assign occupancy  = state_q;
  assign drop_cnt   = drop_cnt_q;

  // Next-state for storage, occupancy, registered in_ready and the drop counter.
  always_comb begin
    up_fire    = in_valid & in_ready_q;
    dn_fire    = out_valid & out_ready;
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      EMPTY: begin
        if (up_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (up_fire && out_ready) begin
          main_d = in_data;
        end else if (up_fire) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (out_ready) begin
          // Drained: out_data keeps its last value, out_valid drops.
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Entries lost to a flush: everything held, minus the one delivered this
    // cycle, plus the upstream beat swallowed this cycle. Never exceeds 2.
    dropped  = state_q - {1'b0, dn_fire} + {1'b0, up_fire};
    drop_sum = {1'b0, drop_cnt_q} + (CNT_W + 1)'(dropped);

    if (flush) begin
      state_d    = EMPTY;
      main_d     = BUBBLE;
      skid_d     = BUBBLE;
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    in_ready_d = (state_d != TWO);
  end

  // State registers; rst wins over flush and clears the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and a saturating drop counter. It replaces the fixed-width, stall-only inter-stage latches (IF/ID and the later stages) between any two stages of the pipelined CPU. Because `in_ready` is driven from a register, no combinational path runs from downstream stall logic to upstream stages. After reset or flush, the stage presents a defined bubble.

## Interface
- `DATA_W`, default 64: payload width (e.g. PC[31:0] concatenated with instruction[31:0]).
- `BUBBLE`, default 0: `DATA_W`-bit value driven on `out_data` after reset or flush.
- `CNT_W`, default 8: width of the flush-drop counter.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous, active-high. Discards all held entries.
- `in_valid` in 1: upstream beat present.
- `in_data` in `DATA_W`: upstream payload.
- `in_ready` out 1: stage can accept a beat. Registered.
- `out_valid` out 1: `out_data` holds a live beat.
- `out_data` out `DATA_W`: payload to the downstream stage.
- `out_ready` in 1: downstream accepts the beat this cycle. Low means stall.
- `out_bubble` out 1: equals `~out_valid`. Provided for legacy control muxing (replaces the old `if_ctrl`).
- `occupancy` out 2: number of held entries, 0 to 2.
- `drop_cnt` out `CNT_W`: count of valid entries discarded by flush. Saturates at all-ones.

## Operation
- Storage: `main` register (drives `out_data`) and `skid` register. Handshake fires upstream when `in_valid & in_ready`, downstream when `out_valid & out_ready`.
- States:
  - EMPTY (occupancy 0)
  - ONE (`main` full)
  - TWO (`main` and `skid` full)
- Transitions from EMPTY:
  - `in_valid`: `main <= in_data`, go to ONE.
  - otherwise stay.
- Transitions from ONE:
  - `in_valid & out_ready`: `main <= in_data`, stay in ONE.
  - `in_valid & ~out_ready`: `skid <= in_data`, go to TWO.
  - `~in_valid & out_ready`: go to EMPTY; `out_data` holds its last value.
  - neither: hold.
- Transitions from TWO:
  - `out_ready`: `main <= skid`, go to ONE.
  - otherwise hold. `in_valid` is ignored because `in_ready` = 0.
- `in_ready` is registered. Its next value is 1 unless the next state is TWO.
- `out_valid` = 1 in ONE or TWO.
- Ordering is strict FIFO. A beat is never duplicated or reordered.
- Flush:
  - Overrides all transitions. Next state is EMPTY, `out_data <= BUBBLE`, `in_ready <= 1`.
  - An upstream handshake in the flush cycle is consumed and discarded.
  - `drop_cnt` increases by (pre-flush occupancy + 1 if an upstream beat fired in that cycle), clamped at 2^`CNT_W`−1.
  - The downstream handshake in the flush cycle still counts as delivered; that entry is not counted as dropped.
- Reset: identical to flush, except `drop_cnt <= 0` and there is no increment. `rst` has priority over `flush`.
- Any bus-holding stall (the old `if_stall`) is expressed as `out_ready` = 0.

## Timing
- Reset values:
  - `out_valid` = 0, `out_bubble` = 1
  - `out_data` = `BUBBLE`
  - `in_ready` = 1
  - `occupancy` = 0
  - `drop_cnt` = 0
- Latency: a beat accepted at edge N is visible on `out_data`/`out_valid` after edge N (one cycle). There is no combinational in-to-out path.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Backpressure: the skid entry absorbs the one beat that is in flight when `out_ready` drops. `in_ready` falls at the edge that fills `skid`.
- Simultaneous flush and reset mid-operation: same rules as above, with no partial state retained. The first valid beat after flush arrives at the earliest one cycle later.
- `drop_cnt` saturation: it stays at all-ones and does not wrap.

## Test plan
- Reset, then stream `in_data` = 0x1000_0000_0000_0001 … +1 for 8 cycles with `out_ready` = 1. Required: each beat appears one cycle later, `occupancy` = 1 throughout, `in_ready` stays 1.
- Stall: drop `out_ready` for 3 cycles mid-stream. Required:
  - the in-flight beat lands in `skid`, `occupancy` = 2, `in_ready` = 0 from the next cycle;
  - on release, beats emerge in order with no loss or duplicate;
  - `in_ready` returns to 1 one cycle after the release.
- Flush in TWO with `in_valid` = 0. Required:
  - next cycle `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1;
  - `drop_cnt` increases by 2.
- Flush coincident with an upstream handshake in ONE and `out_ready` = 1. Required: `drop_cnt` increases by 1; the beat that was in `main` is counted as delivered.
- `CNT_W` = 2: issue 3 flushes, each in TWO. Required: `drop_cnt` = 3 and holds at 3.
- Assert `rst` and `flush` together in TWO. Required: all reset values, `drop_cnt` = 0.
